mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Arbitrates a single-port unified memory between the instruction-fetch path and the load/store path of the multi-cycle CPU. It sequences each access with a req/ack handshake toward memory and a timeout guard. It returns read data and a one-cycle ready pulse to the winning requester, and drives a stall line that the control unit uses to hold its current state.

## Interface
Parameters:
- `ADDR_W`, 32: address width.
- `DATA_W`, 32: data width.
- `TIMEOUT`, 255: maximum cycles to wait for `mem_ack` before aborting; must be ≥1.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-high.
- `if_req` in 1: fetch request, held until `if_ready`.
- `if_addr` in `ADDR_W`: fetch address.
- `if_rdata` out `DATA_W`: fetched word, registered.
- `if_ready` out 1: one-cycle completion pulse for fetch.
- `dm_req` in 1: data request, held until `dm_ready`.
- `dm_we` in 1: 1 = store, 0 = load.
- `dm_addr` in `ADDR_W`: data address.
- `dm_wdata` in `DATA_W`: store data.
- `dm_rdata` out `DATA_W`: load data, registered.
- `dm_ready` out 1: one-cycle completion pulse for data.
- `mem_req` out 1: memory request, level, held until ack or timeout.
- `mem_we` out 1: memory write enable.
- `mem_addr` out `ADDR_W`: memory address.
- `mem_wdata` out `DATA_W`: memory write data.
- `mem_rdata` in `DATA_W`: memory read data, valid with `mem_ack`.
- `mem_ack` in 1: memory completion, single cycle.
- `err` out 1: asserted with ready when the access timed out.
- `stall` out 1: `(if_req & ~if_ready) | (dm_req & ~dm_ready)`, combinational.

## Operation
- **FSM states.** IDLE, ACCESS, DONE.
- **IDLE.**
  - Samples `if_req` and `dm_req`.
  - With a single request, that requester is granted.
  - With both, round-robin on `last_grant`: the side not granted last wins.
  - On grant: latch grant id, address, `we` and wdata into registers; clear the timer; update `last_grant`; go to ACCESS.
  - With no request, remain in IDLE.
- **ACCESS.**
  - `mem_req`=1 and `mem_we`/`mem_addr`/`mem_wdata` driven from the latched registers.
  - On `mem_ack`: for a read, capture `mem_rdata` into the granted side's rdata register; go to DONE with `err`=0.
  - Otherwise the timer increments. When the timer reaches `TIMEOUT` without ack, go to DONE with `err`=1 and load rdata register = 0.
- **DONE.**
  - The granted side's ready = 1, and `err` is valid.
  - Requests are ignored; next state is IDLE.
  - The requester must drop req before the IDLE cycle unless it is issuing a new back-to-back access.
- **Writes.** Rdata registers are unchanged on a write completion.
- **Stray acks.** `mem_ack` is ignored in IDLE and DONE, including a late ack after a timeout.
- **Request stability.** Requester signals must be stable only at the IDLE grant edge. After grant they are don't-care.
- **Reset values.** All outputs are 0 on reset: rdata registers 0, state IDLE, `last_grant` = DM (so IF wins the first tie), timer 0. Reset mid-ACCESS drops `mem_req` immediately (asynchronous) and abandons the access with no ready pulse.

## Timing
- Request high in IDLE cycle 0 → `mem_req` high from cycle 1.
- `mem_ack` in cycle 1+k (k ≥ 0) → ready/rdata valid in cycle 2+k → IDLE in cycle 3+k.
- Minimum latency 2 cycles (req to ready). Minimum issue interval 3 cycles.
- Timeout: with no ack, `mem_req` is high for exactly `TIMEOUT` cycles; ready+`err` follow in the next cycle.
- `stall` drops in the same cycle ready rises.
- Timer width `$clog2(TIMEOUT+1)`; it saturates and never wraps.

## Structure
- `defines.v` gains:
  - MA_IDLE/MA_ACCESS/MA_DONE state encodings (2 bits).
  - `MA_STATE_LEN`.
  - Grant ids GNT_IF=0, GNT_DM=1.
  - `MEM_TIMEOUT` default.
- One sub-module, `mem_arb_timer`: clear/enable counter with a `expired` flag at `TIMEOUT`.

## Test plan
- **Single fetch.** `if_req`, `if_addr`=0x0000_0004, ack with 0x2108_0001 one cycle after `mem_req` → `if_ready` pulse in cycle 3, `if_rdata`=0x2108_0001, `dm_ready`=0, `stall` 1 for cycles 0–2.
- **Store.** `dm_req`, `dm_we`=1, addr 0x0000_0100, wdata 0xCAFE_F00D, ack at first `mem_req` cycle → `mem_we`=1, `mem_wdata`=0xCAFE_F00D, `dm_ready` in cycle 2, `dm_rdata` unchanged (0).
- **Simultaneous requests after reset, both held continuously.** IF served first, then DM. The next tie goes to IF again; grant order IF, DM, IF.
- **Timeout with `TIMEOUT`=4 and no ack.** `mem_req` high exactly 4 cycles → ready with `err`=1 and rdata 0. A late `mem_ack` in IDLE causes no ready pulse.
- **Reset mid-ACCESS.** Assert `rst` while `mem_req`=1 → `mem_req` 0 in the same cycle, no ready pulse, state IDLE. The next IF/DM tie grants IF.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg
// Shared types and constants for the unified-memory arbiter:
//   - ma_state_t   : arbiter FSM encoding (MA_STATE_LEN bits)
//   - GNT_IF/GNT_DM: grant ids for the fetch and load/store sides
//   - MEM_TIMEOUT  : default ack timeout in cycles
//   - rr_pick      : round-robin winner selection
package mem_arbiter_pkg;

  localparam int MA_STATE_LEN = 2;

  typedef enum logic [MA_STATE_LEN-1:0] {
    MA_IDLE   = 2'd0,
    MA_ACCESS = 2'd1,
    MA_DONE   = 2'd2
  } ma_state_t;

  localparam logic GNT_IF = 1'b0;
  localparam logic GNT_DM = 1'b1;

  localparam int MEM_TIMEOUT = 255;

  // Winner among the pending requesters. On a tie the side that was not
  // granted last wins, so neither side can starve the other.
  function automatic logic rr_pick(input logic if_req, input logic dm_req,
                                   input logic last_grant);
    logic win;
    if (if_req && dm_req) win = (last_grant == GNT_DM) ? GNT_IF : GNT_DM;
    else if (if_req)      win = GNT_IF;
    else                  win = GNT_DM;
    return win;
  endfunction

endpackage

// File: rtl/mem_arb_timer.sv
// mem_arb_timer
// Clear/enable cycle counter guarding a memory access.
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   i_clr       : synchronous clear (start of an access)
//   i_en        : count this cycle (access still waiting for ack)
//   o_expired   : this enabled cycle brings the count to TIMEOUT
// The counter saturates at TIMEOUT and never wraps.
module mem_arb_timer #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          r_count <= '0;
    else if (i_clr)                   r_count <= '0;
    else if (i_en && r_count != LIMIT) r_count <= r_count + 1'b1;
  end

  // Flagged one cycle early so the requester sees mem_req for exactly
  // TIMEOUT cycles: the increment that would reach TIMEOUT ends the access.
  assign o_expired = i_en && (r_count == LAST);

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter
// Arbitrates a single-port unified memory between instruction fetch (IF)
// and load/store (DM). One access at a time: IDLE grants, ACCESS holds
// mem_req until mem_ack or timeout, DONE pulses the winner's ready.
// Ports:
//   clk, rst                         : clock, async active-high reset
//   if_req/if_addr/if_rdata/if_ready : fetch side
//   dm_req/dm_we/dm_addr/dm_wdata/dm_rdata/dm_ready : load/store side
//   mem_req/mem_we/mem_addr/mem_wdata/mem_rdata/mem_ack : memory side
//   err       : with ready, the access timed out
//   stall     : some requester is still waiting for its ready
//   dbg_state : current FSM state
// Handshake: a requester raises req and holds it (signals stable at the
// IDLE grant edge) until its one-cycle ready; memory sees mem_req as a level
// held until the single-cycle mem_ack, which is ignored outside ACCESS.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = MEM_TIMEOUT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    if_req,
  input  logic [ADDR_W-1:0]       if_addr,
  output logic [DATA_W-1:0]       if_rdata,
  output logic                    if_ready,
  input  logic                    dm_req,
  input  logic                    dm_we,
  input  logic [ADDR_W-1:0]       dm_addr,
  input  logic [DATA_W-1:0]       dm_wdata,
  output logic [DATA_W-1:0]       dm_rdata,
  output logic                    dm_ready,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic [DATA_W-1:0]       mem_wdata,
  input  logic [DATA_W-1:0]       mem_rdata,
  input  logic                    mem_ack,
  output logic                    err,
  output logic                    stall,
  output logic [MA_STATE_LEN-1:0] dbg_state
);

  ma_state_t         r_state, w_next;
  logic              r_gnt, r_last, r_we, r_err;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata, r_if_rdata, r_dm_rdata;
  logic              w_grant, w_win, w_expired, w_access, w_done;

  assign w_win    = rr_pick(if_req, dm_req, r_last);
  assign w_grant  = (r_state == MA_IDLE) && (if_req || dm_req);
  assign w_access = (r_state == MA_ACCESS);
  assign w_done   = (r_state == MA_DONE);

  mem_arb_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk       (clk),
    .rst       (rst),
    .i_clr     (w_grant),
    .i_en      (w_access && !mem_ack),
    .o_expired (w_expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= MA_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      MA_IDLE:   if (if_req || dm_req)     w_next = MA_ACCESS;
      MA_ACCESS: if (mem_ack || w_expired) w_next = MA_DONE;
      MA_DONE:                             w_next = MA_IDLE;
      default:                             w_next = MA_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_gnt      <= GNT_IF;
      r_last     <= GNT_DM;
      r_we       <= 1'b0;
      r_err      <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_if_rdata <= '0;
      r_dm_rdata <= '0;
    end else begin
      if (w_grant) begin
        r_gnt   <= w_win;
        r_last  <= w_win;
        r_we    <= (w_win == GNT_DM) ? dm_we : 1'b0;
        r_addr  <= (w_win == GNT_DM) ? dm_addr : if_addr;
        r_wdata <= (w_win == GNT_DM) ? dm_wdata : '0;
      end
      if (w_access) begin
        // An ack arriving on the expiry cycle still counts as success.
        if (mem_ack) begin
          r_err <= 1'b0;
          if (!r_we) begin
            if (r_gnt == GNT_IF) r_if_rdata <= mem_rdata;
            else                 r_dm_rdata <= mem_rdata;
          end
        end else if (w_expired) begin
          r_err <= 1'b1;
          if (!r_we) begin
            if (r_gnt == GNT_IF) r_if_rdata <= '0;
            else                 r_dm_rdata <= '0;
          end
        end
      end
    end
  end

  assign mem_req   = w_access;
  assign mem_we    = w_access && r_we;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;

  assign if_ready  = w_done && (r_gnt == GNT_IF);
  assign dm_ready  = w_done && (r_gnt == GNT_DM);
  assign err       = w_done && r_err;
  assign if_rdata  = r_if_rdata;
  assign dm_rdata  = r_dm_rdata;

  assign stall     = (if_req && !if_ready) || (dm_req && !dm_ready);
  assign dbg_state = r_state;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic [31:0] if_rdata;
  logic        if_ready;
  logic        dm_req = 1'b0;
  logic        dm_we = 1'b0;
  logic [31:0] dm_addr = '0;
  logic [31:0] dm_wdata = '0;
  logic [31:0] dm_rdata;
  logic        dm_ready;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;
  logic        err;
  logic        stall;
  logic [1:0]  dbg_state;

  int n_vec = 0;
  int n_bad = 0;
  logic [31:0] exp_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, required finish before 200000");
    $fatal(1, "watchdog");
  end

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_ready(dm_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .err(err), .stall(stall), .dbg_state(dbg_state)
  );

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    if_req = 1'b0; dm_req = 1'b0; mem_ack = 1'b0;
    next_cycle();
    next_cycle();
    rst = 1'b0;
  endtask

  task automatic wait_mem_req(input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (mem_req !== 1'b1 && n < 20);
    chk(tag, {31'd0, mem_req}, 32'd1);
  endtask

  // 0 = IF ready, 1 = DM ready, 2 = none, 3 = both
  function automatic logic [31:0] ready_side();
    if (if_ready && dm_ready) return 32'd3;
    if (if_ready)             return 32'd0;
    if (dm_ready)             return 32'd1;
    return 32'd2;
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    do_reset();
    @(negedge clk);
    chk("rst_state", {30'd0, dbg_state}, 32'd0);
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_if_rdata", if_rdata, 32'd0);
    chk("rst_dm_rdata", dm_rdata, 32'd0);
    chk("rst_ready", ready_side(), 32'd2);
    chk("rst_stall", {31'd0, stall}, 32'd0);

    // Single fetch, ack one cycle after mem_req rises.
    next_cycle();                                  // cycle 0
    if_req = 1'b1; if_addr = 32'h0000_0004;
    @(negedge clk);
    chk("f_c0_stall", {31'd0, stall}, 32'd1);
    chk("f_c0_mem_req", {31'd0, mem_req}, 32'd0);
    next_cycle();                                  // cycle 1
    @(negedge clk);
    chk("f_c1_mem_req", {31'd0, mem_req}, 32'd1);
    chk("f_c1_addr", mem_addr, 32'h0000_0004);
    chk("f_c1_we", {31'd0, mem_we}, 32'd0);
    chk("f_c1_stall", {31'd0, stall}, 32'd1);
    next_cycle();                                  // cycle 2
    mem_ack = 1'b1; mem_rdata = 32'h2108_0001;
    @(negedge clk);
    chk("f_c2_stall", {31'd0, stall}, 32'd1);
    chk("f_c2_ready", ready_side(), 32'd2);
    next_cycle();                                  // cycle 3
    mem_ack = 1'b0; mem_rdata = 32'h0;
    @(negedge clk);
    chk("f_c3_ready", ready_side(), 32'd0);
    chk("f_c3_rdata", if_rdata, 32'h2108_0001);
    chk("f_c3_err", {31'd0, err}, 32'd0);
    chk("f_c3_stall", {31'd0, stall}, 32'd0);
    chk("f_c3_mem_req", {31'd0, mem_req}, 32'd0);
    if_req = 1'b0;
    next_cycle();                                  // cycle 4
    @(negedge clk);
    chk("f_c4_state", {30'd0, dbg_state}, 32'd0);
    chk("f_c4_ready", ready_side(), 32'd2);

    // Store, ack on the first mem_req cycle; bogus rdata must be ignored.
    next_cycle();
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h0000_0100; dm_wdata = 32'hCAFE_F00D;
    next_cycle();                                  // cycle 1
    mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("s_mem_req", {31'd0, mem_req}, 32'd1);
    chk("s_mem_we", {31'd0, mem_we}, 32'd1);
    chk("s_mem_addr", mem_addr, 32'h0000_0100);
    chk("s_mem_wdata", mem_wdata, 32'hCAFE_F00D);
    next_cycle();                                  // cycle 2
    mem_ack = 1'b0;
    @(negedge clk);
    chk("s_ready", ready_side(), 32'd1);
    chk("s_dm_rdata", dm_rdata, 32'd0);
    chk("s_err", {31'd0, err}, 32'd0);
    dm_req = 1'b0; dm_we = 1'b0;
    next_cycle();

    // Load acked on the last cycle before timeout: ack wins, no err.
    next_cycle();
    dm_req = 1'b1; dm_addr = 32'h0000_0200;
    for (int c = 1; c <= 4; c++) begin
      next_cycle();
      if (c == 4) begin mem_ack = 1'b1; mem_rdata = 32'h1234_5678; end
      @(negedge clk);
      chk("l_mem_req", {31'd0, mem_req}, 32'd1);
    end
    next_cycle();                                  // cycle 5
    mem_ack = 1'b0;
    @(negedge clk);
    chk("l_ready", ready_side(), 32'd1);
    chk("l_err", {31'd0, err}, 32'd0);
    chk("l_dm_rdata", dm_rdata, 32'h1234_5678);
    chk("l_if_rdata_kept", if_rdata, 32'h2108_0001);
    dm_req = 1'b0;

    // Tie after reset, both held continuously: IF, DM, IF.
    do_reset();
    if_req = 1'b1; if_addr = 32'h0000_0010;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h0000_0020;
    exp_q.push_back(32'd0); exp_q.push_back(32'd1); exp_q.push_back(32'd0);
    for (int t = 0; t < 3; t++) begin
      logic [31:0] side;
      side = exp_q.pop_front();
      wait_mem_req("tie_wait");
      chk("tie_addr", mem_addr, (side == 32'd0) ? 32'h0000_0010 : 32'h0000_0020);
      next_cycle();
      mem_ack = 1'b1; mem_rdata = 32'h0000_00A0 + t;
      next_cycle();
      mem_ack = 1'b0;
      @(negedge clk);
      chk("tie_gnt", ready_side(), side);
      chk("tie_rdata", (side == 32'd0) ? if_rdata : dm_rdata, 32'h0000_00A0 + t);
    end
    if_req = 1'b0; dm_req = 1'b0;
    next_cycle();

    // Timeout (TIMEOUT=4): mem_req for exactly 4 cycles, then ready+err.
    next_cycle();
    if_req = 1'b1; if_addr = 32'h0000_0040;
    for (int c = 1; c <= 4; c++) begin
      next_cycle();
      @(negedge clk);
      chk("to_mem_req", {31'd0, mem_req}, 32'd1);
      chk("to_no_ready", ready_side(), 32'd2);
    end
    next_cycle();                                  // cycle 5
    @(negedge clk);
    chk("to_mem_req_drop", {31'd0, mem_req}, 32'd0);
    chk("to_ready", ready_side(), 32'd0);
    chk("to_err", {31'd0, err}, 32'd1);
    chk("to_rdata", if_rdata, 32'd0);
    if_req = 1'b0;
    next_cycle();                                  // IDLE: late ack
    mem_ack = 1'b1; mem_rdata = 32'h5555_AAAA;
    @(negedge clk);
    chk("late_ready", ready_side(), 32'd2);
    next_cycle();
    mem_ack = 1'b0;
    @(negedge clk);
    chk("late_ready2", ready_side(), 32'd2);
    chk("late_err", {31'd0, err}, 32'd0);
    chk("late_state", {30'd0, dbg_state}, 32'd0);
    chk("late_rdata", if_rdata, 32'd0);

    // Reset in the middle of an access.
    next_cycle();
    dm_req = 1'b1; dm_addr = 32'h0000_0080;
    next_cycle();
    @(negedge clk);
    chk("rm_mem_req", {31'd0, mem_req}, 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("rm_mem_req_drop", {31'd0, mem_req}, 32'd0);
    chk("rm_state", {30'd0, dbg_state}, 32'd0);
    chk("rm_ready", ready_side(), 32'd2);
    dm_req = 1'b0;
    next_cycle();
    next_cycle();
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("rm_no_ready", ready_side(), 32'd2);
      next_cycle();
    end
    if_req = 1'b1; if_addr = 32'h0000_0300;
    dm_req = 1'b1; dm_addr = 32'h0000_0400;
    wait_mem_req("rm_tie_wait");
    chk("rm_tie_addr", mem_addr, 32'h0000_0300);
    next_cycle();
    mem_ack = 1'b1; mem_rdata = 32'h0BAD_F00D;
    next_cycle();
    mem_ack = 1'b0;
    @(negedge clk);
    chk("rm_tie_gnt", ready_side(), 32'd0);
    chk("rm_tie_rdata", if_rdata, 32'h0BAD_F00D);
    if_req = 1'b0; dm_req = 1'b0;
    next_cycle();
    next_cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
